// File: rtl/alu_disp_pkg.sv
// Shared types, opcode codes and 7-segment helpers for the ALU result display stage.
package alu_disp_pkg;

    typedef struct packed {
        logic [3:0] res;
        logic       car;
        logic       of;
        logic [2:0] ctrl;
    } alu_entry_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low {dp,g..a}; dp is returned unlit.
    function automatic logic [7:0] hex2seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_result_disp_seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder with dp, minus and blank controls.
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    input  logic       minus,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = hex2seg(digit);
        if (minus) seg = SEG_MINUS;
        seg[7] = ~dp;
        if (blank) seg = SEG_BLANK;
    end

endmodule

// File: rtl/alu_result_disp.sv
// ALU result history buffer with browse/auto-scan and registered 3-digit 7-seg display.
// Optional blinking of overflowed values is enabled by defining ALU_DISP_BLINK_EN.
module alu_result_disp
    import alu_disp_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SCAN_DIV  = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_res,
    input  logic                   in_car,
    input  logic                   in_of,
    input  logic [2:0]             in_ctrl,
    input  logic                   lock,
    input  logic                   btn_next,
    input  logic                   auto_en,
    output logic [7:0]             seg0,
    output logic [7:0]             seg1,
    output logic [7:0]             seg2,
    output logic                   led_car,
    output logic                   led_of,
    output logic [$clog2(DEPTH):0] hist_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

    alu_entry_t        hist_q [DEPTH];
    alu_entry_t        in_entry, shown;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, view_idx_q, view_idx_d, rd_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              full, accept, scan_tick, browse;
    logic              empty, neg, blink_on;
    logic [3:0]        mag;
    logic [7:0]        seg0_d, seg1_d, seg2_d, seg0_q, seg1_q, seg2_q;
    logic              led_car_d, led_of_d, led_car_q, led_of_q;

    always_comb begin
        in_entry   = '{res: in_res, car: in_car, of: in_of, ctrl: in_ctrl};
        full       = (count_q == CNT_W'(DEPTH));
        in_ready   = !(lock && full);
        accept     = in_valid && in_ready;
        scan_cnt_d = '0;
        scan_tick  = 1'b0;
        if (auto_en) begin
            if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) scan_tick  = 1'b1;
            else                                     scan_cnt_d = scan_cnt_q + 1'b1;
        end
        browse     = btn_next || scan_tick;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        view_idx_d = view_idx_q;
        // An accept always wins over a browse in the same cycle.
        if (accept) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            view_idx_d = '0;
            if (!full) count_d = count_q + 1'b1;
        end else if (browse && count_q != '0) begin
            if (CNT_W'(view_idx_q) + 1'b1 >= count_q) view_idx_d = '0;
            else                                      view_idx_d = view_idx_q + 1'b1;
        end
    end

    always_comb begin
        rd_idx    = wr_ptr_q - 1'b1 - view_idx_q;
        shown     = hist_q[rd_idx];
        empty     = (count_q == '0);
        neg       = (shown.ctrl == ALU_ADD || shown.ctrl == ALU_SUB) && shown.res[3];
        mag       = neg ? (~shown.res + 4'd1) : shown.res;
        led_car_d = !empty && shown.car;
        led_of_d  = !empty && shown.of;
    end

`ifdef ALU_DISP_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_on = blink_phase_q && shown.of;
`else
    assign blink_on = 1'b0;
`endif

    seg7_decode u_seg0 (
        .digit (mag),
        .dp    (1'b0),
        .minus (1'b0),
        .blank (empty || blink_on),
        .seg   (seg0_d)
    );

    seg7_decode u_seg1 (
        .digit (4'd0),
        .dp    (1'b0),
        .minus (1'b1),
        .blank (empty || !neg || blink_on),
        .seg   (seg1_d)
    );

    seg7_decode u_seg2 (
        .digit (4'(view_idx_q)),
        .dp    (shown.of),
        .minus (1'b0),
        .blank (empty),
        .seg   (seg2_d)
    );

    always_ff @(posedge clk) begin
        if (accept) hist_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            view_idx_q <= '0;
            scan_cnt_q <= '0;
            seg0_q     <= SEG_BLANK;
            seg1_q     <= SEG_BLANK;
            seg2_q     <= SEG_BLANK;
            led_car_q  <= 1'b0;
            led_of_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            view_idx_q <= view_idx_d;
            scan_cnt_q <= scan_cnt_d;
            seg0_q     <= seg0_d;
            seg1_q     <= seg1_d;
            seg2_q     <= seg2_d;
            led_car_q  <= led_car_d;
            led_of_q   <= led_of_d;
        end
    end

    assign seg0     = seg0_q;
    assign seg1     = seg1_q;
    assign seg2     = seg2_q;
    assign led_car  = led_car_q;
    assign led_of   = led_of_q;
    assign hist_cnt = count_q;

endmodule
